// File: rtl/mem_stage_hs.sv
// MEM stage with req/gnt/rvalid data-memory handshake, sub-word load/store and MEM/WB register; MEM_MISALIGN_EXC_EN enables misalignment trap.
// Latency: non-memory ops and granted stores reach WB next edge; loads reach WB on the edge ending the rvalid cycle.
// Backpressure: o_stall holds upstream while an access awaits i_gnt or i_rvalid; WB receives bubbles meanwhile.
module mem_stage_hs #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic                  i_MemRead,
  input  logic                  i_MemWrite,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [ADDR_W-1:0]     i_ALUOut,
  input  logic [DATA_W-1:0]     i_RTData,
  input  logic                  i_Overflow,
  input  logic                  i_Mem2Reg,
  input  logic                  i_RegWrite,
  input  logic [REG_AW-1:0]     i_RegAddrW,
  output logic                  o_stall,
  output logic                  o_req,
  output logic                  o_we,
  output logic [ADDR_W-1:0]     o_addr,
  output logic [DATA_W/8-1:0]   o_be,
  output logic [DATA_W-1:0]     o_wdata,
  input  logic                  i_gnt,
  input  logic                  i_rvalid,
  input  logic [DATA_W-1:0]     i_rdata,
  output logic                  o_WB_valid,
  output logic                  o_WB_Mem2Reg,
  output logic                  o_WB_RegWrite,
  output logic [DATA_W-1:0]     o_WB_MemData,
  output logic [DATA_W-1:0]     o_WB_ALUData,
  output logic [REG_AW-1:0]     o_WB_RegAddrW,
  output logic                  o_WB_exc
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t state_q, state_d;

  logic [OFF_W-1:0] off_raw;
  logic [OFF_W-1:0] off;
  logic [OFF_W-1:0] size_mask;
  logic             misaligned;
  logic             misalign_exc;
  logic             access_raw;
  logic             access;
  logic             is_write;
  logic             req;
  logic             complete;

  assign access_raw = i_valid & (i_MemRead | i_MemWrite) & ~i_Overflow;
  assign is_write   = i_MemWrite;
  assign off_raw    = i_ALUOut[OFF_W-1:0];
  // Low i_size bits of the offset must be zero for a naturally aligned access.
  assign size_mask  = ~({OFF_W{1'b1}} << i_size);
  assign misaligned = |(off_raw & size_mask);

`ifdef MEM_MISALIGN_EXC_EN
  assign off          = off_raw;
  assign misalign_exc = access_raw & misaligned;
`else
  assign off          = off_raw & ~size_mask;
  assign misalign_exc = 1'b0;
`endif

  assign access = access_raw & ~misalign_exc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req      = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          req = 1'b1;
          if (i_gnt) begin
            if (is_write) complete = 1'b1;
            else          state_d  = RESP;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (access) begin
          req = 1'b1;
          if (i_gnt) begin
            if (is_write) begin
              complete = 1'b1;
              state_d  = IDLE;
            end else begin
              state_d = RESP;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      RESP: begin
        if (i_rvalid) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_req   = req & ~rst;
  assign o_we    = o_req & is_write;
  assign o_stall = access & ~complete & ~rst;
  assign o_addr  = {i_ALUOut[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  logic [15:0] be_mask;
  logic [15:0] be_full;

  always_comb begin
    be_mask = 16'h00FF;
    case (i_size)
      2'd0:    be_mask = 16'h0001;
      2'd1:    be_mask = 16'h0003;
      2'd2:    be_mask = 16'h000F;
      default: be_mask = 16'h00FF;
    endcase
    be_full = be_mask << off;
  end

  assign o_be = be_full[NB-1:0];

  always_comb begin
    o_wdata = '0;
    case (i_size)
      2'd0: for (int i = 0; i < NB; i++)     o_wdata[8*i +: 8]   = i_RTData[7:0];
      2'd1: for (int i = 0; i < NB/2; i++)   o_wdata[16*i +: 16] = i_RTData[15:0];
      2'd2: for (int i = 0; i < NB/4; i++)   o_wdata[32*i +: 32] = i_RTData[31:0];
      default: o_wdata = i_RTData;
    endcase
  end

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ld_data;
  logic              sgn;

  always_comb begin
    shifted = i_rdata >> {off, 3'b000};
    sgn     = shifted[DATA_W-1];
    case (i_size)
      2'd0:    sgn = shifted[7];
      2'd1:    sgn = shifted[15];
      2'd2:    sgn = shifted[31];
      default: sgn = shifted[DATA_W-1];
    endcase
    ld_data = shifted;
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= (8 << i_size)) ld_data[i] = sgn & ~i_unsigned;
    end
  end

  logic              wb_valid_q,    wb_valid_d;
  logic              wb_mem2reg_q,  wb_mem2reg_d;
  logic              wb_regwrite_q, wb_regwrite_d;
  logic [DATA_W-1:0] wb_memdata_q,  wb_memdata_d;
  logic [DATA_W-1:0] wb_aludata_q,  wb_aludata_d;
  logic [REG_AW-1:0] wb_regaddr_q,  wb_regaddr_d;
  logic              wb_exc_q,      wb_exc_d;

  // A stalled cycle pushes an all-zero bubble into WB.
  always_comb begin
    wb_valid_d    = 1'b0;
    wb_mem2reg_d  = 1'b0;
    wb_regwrite_d = 1'b0;
    wb_memdata_d  = '0;
    wb_aludata_d  = '0;
    wb_regaddr_d  = '0;
    wb_exc_d      = 1'b0;
    if (!o_stall) begin
      wb_valid_d    = i_valid;
      wb_mem2reg_d  = i_Mem2Reg;
      wb_regwrite_d = i_RegWrite & ~i_Overflow & ~misalign_exc;
      wb_memdata_d  = (access & ~is_write) ? ld_data : '0;
      wb_aludata_d  = DATA_W'(i_ALUOut);
      wb_regaddr_d  = i_RegAddrW;
      wb_exc_d      = misalign_exc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q    <= 1'b0;
      wb_mem2reg_q  <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_memdata_q  <= '0;
      wb_aludata_q  <= '0;
      wb_regaddr_q  <= '0;
      wb_exc_q      <= 1'b0;
    end else begin
      wb_valid_q    <= wb_valid_d;
      wb_mem2reg_q  <= wb_mem2reg_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_memdata_q  <= wb_memdata_d;
      wb_aludata_q  <= wb_aludata_d;
      wb_regaddr_q  <= wb_regaddr_d;
      wb_exc_q      <= wb_exc_d;
    end
  end

  assign o_WB_valid    = wb_valid_q;
  assign o_WB_Mem2Reg  = wb_mem2reg_q;
  assign o_WB_RegWrite = wb_regwrite_q;
  assign o_WB_MemData  = wb_memdata_q;
  assign o_WB_ALUData  = wb_aludata_q;
  assign o_WB_RegAddrW = wb_regaddr_q;
  assign o_WB_exc      = wb_exc_q;

endmodule
